// File: rtl/ss_sgx_if.sv
// Wishbone master bundle between ss_sgx and the descriptor/buffer memory.
// Byte address is {word address, 3'b000}; read data arrives as two 32-bit halves.
interface ss_sgx_if #(
  parameter int AW = 32
);
  logic          wbs_cyc;
  logic          wbs_stb;
  logic          wbs_we;
  logic          wbs_cab;
  logic [7:0]    wbs_sel;
  logic [AW-1:0] wbs_adr;
  logic [31:0]   wbs_dat_o;
  logic [31:0]   wbs_dat64_o;
  logic          wbs_ack;
  logic          wbs_rty;
  logic          wbs_err;

  modport master (
    output wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr,
    input  wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
  );

  modport slave (
    input  wbs_cyc, wbs_stb, wbs_we, wbs_cab, wbs_sel, wbs_adr,
    output wbs_dat_o, wbs_dat64_o, wbs_ack, wbs_rty, wbs_err
  );
endinterface

// File: rtl/ss_sgx.sv
// Scatter-gather descriptor walker: fetches 2-beat descriptors and streams each
// buffer as Wishbone bursts of at most MAX_BURST beats, with bounded retry.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | waiting for cmd_valid; cmd_ready high
//   S_D_REQ  | fetching descriptor beat 0 (addr/len/last) then beat 1 (next)
//   S_B_REQ  | buffer burst in flight, one ss_xfer per ack
//   S_B_WAIT | buffer pending, waiting for ss_start (or ss_end)
//   S_NEXT   | decide: finish on sg_last/ss_end, else fetch sg_next
//   S_GAP    | one dead cycle with cyc low before re-issuing a cycle
//   S_END    | job finished, waiting for ss_done
//   S_PANIC  | bus error or retry exhaustion, err held, waiting for ss_done
module ss_sgx #(
  parameter int AW        = 32,
  parameter int LW        = 16,
  parameter int MAX_BURST = 16,
  parameter int RTY_MAX   = 7
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          rw,
  input  logic          cmd_valid,
  input  logic [AW-4:0] cmd_next,
  output logic          cmd_ready,
  ss_sgx_if.master      wbs,
  input  logic          ss_start,
  input  logic          ss_stop,
  input  logic          ss_end,
  input  logic          ss_done,
  output logic          ss_xfer,
  output logic          ss_last,
  output logic [AW-4:0] sg_addr,
  output logic [LW-1:0] sg_len,
  output logic [AW-4:0] sg_next,
  output logic [7:0]    sg_state,
  output logic          c_done
);

  localparam int WA = AW - 3;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [3:0]    RTY_LIM   = 4'(RTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_REQ  = 3'd1,
    S_B_REQ  = 3'd2,
    S_B_WAIT = 3'd3,
    S_NEXT   = 3'd4,
    S_GAP    = 3'd5,
    S_END    = 3'd6,
    S_PANIC  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [WA-1:0] addr_q, addr_d;
  logic [WA-1:0] next_q, next_d;
  logic [LW-1:0] len_q, len_d;
  logic          last_q, last_d;
  logic [2:0]    err_q, err_d;
  logic [3:0]    rty_q, rty_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          didx_q, didx_d;
  logic          phase_q, phase_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          ack_ok;
  logic          rty_ok;
  logic          unused_bits;

  // Termination priority: err > rty > ack.
  assign ack_ok = wbs.wbs_ack && !wbs.wbs_rty && !wbs.wbs_err;
  assign rty_ok = wbs.wbs_rty && !wbs.wbs_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      next_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 3'd0;
      rty_q   <= 4'd0;
      bcnt_q  <= '0;
      didx_q  <= 1'b0;
      phase_q <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      next_q  <= next_d;
      len_q   <= len_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      bcnt_q  <= bcnt_d;
      didx_q  <= didx_d;
      phase_q <= phase_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    next_d  = next_q;
    len_d   = len_q;
    last_d  = last_q;
    err_d   = err_q;
    rty_d   = rty_q;
    bcnt_d  = bcnt_q;
    didx_d  = didx_q;
    phase_d = phase_q;
    adr_d   = adr_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          next_d  = cmd_next;
          last_d  = 1'b0;
          err_d   = 3'd0;
          rty_d   = 4'd0;
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (ss_end || last_q) begin
          state_d = S_END;
        end else begin
          adr_d   = {next_q, 3'b000};
          didx_d  = 1'b0;
          state_d = S_D_REQ;
        end
      end

      S_D_REQ: begin
        if (wbs.wbs_err) begin
          err_d   = 3'd1;
          state_d = S_PANIC;
        end else if (rty_ok) begin
          rty_d = rty_q + 4'd1;
          if (rty_q + 4'd1 == RTY_LIM) begin
            err_d   = 3'd3;
            state_d = S_PANIC;
          end else begin
            phase_d = 1'b0;
            state_d = S_GAP;
          end
        end else if (ack_ok) begin
          rty_d = 4'd0;
          if (!didx_q) begin
            addr_d = wbs.wbs_dat_o[AW-1:3];
            len_d  = wbs.wbs_dat64_o[LW+2:3];
            last_d = wbs.wbs_dat64_o[20];
            didx_d = 1'b1;
            adr_d  = adr_q + AW'(8);
          end else begin
            next_d  = wbs.wbs_dat64_o[AW-1:3];
            state_d = (len_q == '0) ? S_NEXT : S_B_WAIT;
          end
        end
      end

      S_B_REQ: begin
        if (wbs.wbs_err) begin
          err_d   = 3'd2;
          state_d = S_PANIC;
        end else if (rty_ok) begin
          rty_d = rty_q + 4'd1;
          if (rty_q + 4'd1 == RTY_LIM) begin
            err_d   = 3'd4;
            state_d = S_PANIC;
          end else begin
            phase_d = 1'b1;
            state_d = S_GAP;
          end
        end else if (ack_ok) begin
          rty_d  = 4'd0;
          addr_d = addr_q + 1'b1;
          len_d  = len_q - 1'b1;
          bcnt_d = bcnt_q + 1'b1;
          adr_d  = {addr_q + 1'b1, 3'b000};
          if (len_q == LW'(1)) begin
            state_d = S_NEXT;
          end else if (ss_stop) begin
            state_d = S_B_WAIT;
          end else if (bcnt_q + 1'b1 == BURST_MAX) begin
            phase_d = 1'b1;
            state_d = S_GAP;
          end
        end
      end

      S_B_WAIT: begin
        if (ss_end) begin
          state_d = S_END;
        end else if (ss_start) begin
          adr_d   = {addr_q, 3'b000};
          bcnt_d  = '0;
          state_d = S_B_REQ;
        end
      end

      // Address register still points at the beat to (re)issue.
      S_GAP: begin
        if (phase_q) begin
          bcnt_d  = '0;
          state_d = S_B_REQ;
        end else begin
          state_d = S_D_REQ;
        end
      end

      S_END: begin
        if (ss_done) state_d = S_IDLE;
      end

      S_PANIC: begin
        if (ss_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    cyc_d = (state_d == S_D_REQ) || (state_d == S_B_REQ);
    we_d  = (state_d == S_B_REQ) ? rw : 1'b0;
  end

  assign wbs.wbs_cyc = cyc_q;
  assign wbs.wbs_stb = cyc_q;
  assign wbs.wbs_cab = cyc_q;
  assign wbs.wbs_we  = we_q;
  assign wbs.wbs_sel = {8{cyc_q}};
  assign wbs.wbs_adr = adr_q;

  assign ss_xfer   = !wb_rst_i && (state_q == S_B_REQ) && ack_ok;
  assign ss_last   = ss_xfer && (len_q == LW'(1));
  assign cmd_ready = (state_q == S_IDLE);
  assign c_done    = (state_q == S_IDLE) || (state_q == S_END);

  assign sg_addr  = addr_q;
  assign sg_len   = len_q;
  assign sg_next  = next_q;
  assign sg_state = {last_q, err_q, 1'b0, state_q};

  assign unused_bits = ^{wbs.wbs_dat_o, wbs.wbs_dat64_o};

endmodule

// File: tb/tb_ss_sgx.sv
// Directed bench for ss_sgx: zero-wait slave with address-targeted rty/err,
// monitor queues of beats, descriptor fetches and burst shapes.
module tb_ss_sgx;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rw = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [AW-4:0] cmd_next = '0;
  logic          cmd_ready;
  logic          ss_start = 1'b1;
  logic          ss_stop = 1'b0;
  logic          ss_end = 1'b0;
  logic          ss_done = 1'b0;
  logic          ss_xfer, ss_last, c_done;
  logic [AW-4:0] sg_addr, sg_next;
  logic [LW-1:0] sg_len;
  logic [7:0]    sg_state;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] mem_lo [64];
  logic [31:0] mem_hi [64];
  int rty_w = -1, rty_req = 0, rty_base = 0, rty_seen = 0;
  int err_w = -1;
  bit err_arm = 1'b0;

  int xa_q[$];
  bit xl_q[$];
  bit xw_q[$];
  int da_q[$];
  int bc_q[$];
  int bg_q[$];

  ss_sgx_if #(.AW(AW)) wb ();

  ss_sgx #(.AW(AW), .LW(LW), .MAX_BURST(4), .RTY_MAX(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .rw       (rw),
    .cmd_valid(cmd_valid),
    .cmd_next (cmd_next),
    .cmd_ready(cmd_ready),
    .wbs      (wb),
    .ss_start (ss_start),
    .ss_stop  (ss_stop),
    .ss_end   (ss_end),
    .ss_done  (ss_done),
    .ss_xfer  (ss_xfer),
    .ss_last  (ss_last),
    .sg_addr  (sg_addr),
    .sg_len   (sg_len),
    .sg_next  (sg_next),
    .sg_state (sg_state),
    .c_done   (c_done)
  );

  always #5 clk = ~clk;

  // Slave responds in the same cycle; response is set up at the falling edge.
  always @(negedge clk) begin
    int w;
    bit r, e;
    w = int'(wb.wbs_adr[AW-1:3]);
    wb.wbs_dat_o   = mem_lo[w[5:0]];
    wb.wbs_dat64_o = mem_hi[w[5:0]];
    e = wb.wbs_cyc && err_arm && (w == err_w);
    r = wb.wbs_cyc && (w == rty_w) && ((rty_seen - rty_base) < rty_req);
    if (r) rty_seen++;
    wb.wbs_err = e;
    wb.wbs_rty = r;
    wb.wbs_ack = wb.wbs_cyc && !r && !e;
  end

  bit prev_cyc = 1'b0;
  int cur_x = 0, low_cnt = 0, cur_gap = 0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_cyc = 1'b0;
      cur_x    = 0;
      low_cnt  = 0;
    end else begin
      if (ss_xfer) begin
        xa_q.push_back(int'(wb.wbs_adr[AW-1:3]));
        xl_q.push_back(ss_last);
        xw_q.push_back(wb.wbs_we);
      end
      if (wb.wbs_ack && sg_state[2:0] == 3'd1) da_q.push_back(int'(wb.wbs_adr[AW-1:3]));
      if (wb.wbs_cyc) begin
        if (!prev_cyc) begin
          cur_gap = low_cnt;
          low_cnt = 0;
          cur_x   = 0;
        end
        if (ss_xfer) cur_x++;
      end else begin
        if (prev_cyc && cur_x > 0) begin
          bc_q.push_back(cur_x);
          bg_q.push_back(cur_gap);
        end
        low_cnt++;
      end
      prev_cyc = wb.wbs_cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_st(input string tag, input logic [2:0] st, input int max);
    int i = 0;
    while (sg_state[2:0] !== st && i < max) begin
      tick();
      i++;
    end
    chk(tag, sg_state[2:0], st);
  endtask

  task automatic set_desc(input int w, input int a, input int len, input bit last, input int nxt);
    mem_lo[w]   = a << 3;
    mem_hi[w]   = (32'(last) << 20) | (len << 3);
    mem_lo[w+1] = 32'd0;
    mem_hi[w+1] = nxt << 3;
  endtask

  task automatic start_cmd(input int w);
    cmd_next  = (AW-3)'(w);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    ss_done = 1'b1;
    tick();
    ss_done = 1'b0;
    chk({tag, "_idle"}, sg_state[2:0], 3'd0);
    chk({tag, "_rdy"}, cmd_ready, 1'b1);
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_cyc"}, wb.wbs_cyc, 1'b0);
    chk({p, "_stb"}, wb.wbs_stb, 1'b0);
    chk({p, "_we"},  wb.wbs_we,  1'b0);
    chk({p, "_cab"}, wb.wbs_cab, 1'b0);
    chk({p, "_sel"}, wb.wbs_sel, 8'h00);
    chk({p, "_adr"}, wb.wbs_adr, 32'h0);
    chk({p, "_xfer"}, ss_xfer, 1'b0);
    chk({p, "_last"}, ss_last, 1'b0);
    chk({p, "_addr"}, sg_addr, 29'h0);
    chk({p, "_len"},  sg_len,  16'h0);
    chk({p, "_next"}, sg_next, 29'h0);
    chk({p, "_state"}, sg_state, 8'h00);
    chk({p, "_cdone"}, c_done, 1'b1);
    chk({p, "_rdy"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xb, db, bb, rb;
    for (int i = 0; i < 64; i++) begin
      mem_lo[i] = 32'd0;
      mem_hi[i] = 32'd0;
    end
    set_desc(4,  100, 3,  1'b1, 0);
    set_desc(8,  200, 2,  1'b0, 12);
    set_desc(12, 300, 1,  1'b1, 0);
    set_desc(16, 400, 10, 1'b1, 0);
    set_desc(20, 500, 2,  1'b1, 0);
    set_desc(24, 600, 2,  1'b1, 0);
    set_desc(28, 650, 2,  1'b1, 0);
    set_desc(32, 700, 0,  1'b0, 36);
    set_desc(36, 800, 1,  1'b1, 0);
    set_desc(40, 900, 8,  1'b1, 0);

    repeat (3) tick();
    chk_rst("rst0");
    rst = 1'b0;
    tick();

    // Single descriptor, len 3, read.
    xb = xa_q.size(); db = da_q.size();
    rw = 1'b0;
    start_cmd(4);
    chk("t1_st_next", sg_state[2:0], 3'd4);
    chk("t1_cyc_lo", wb.wbs_cyc, 1'b0);
    tick();
    chk("t1_cyc_hi", wb.wbs_cyc, 1'b1);
    chk("t1_adr", wb.wbs_adr, 32'd32);
    chk("t1_sel", wb.wbs_sel, 8'hFF);
    chk("t1_we", wb.wbs_we, 1'b0);
    wait_st("t1_end", 3'd6, 200);
    chk("t1_cdone", c_done, 1'b1);
    chk("t1_sgst", sg_state, 8'h86);
    chk("t1_nd", da_q.size() - db, 2);
    chk("t1_d0", da_q[db], 4);
    chk("t1_d1", da_q[db+1], 5);
    chk("t1_nx", xa_q.size() - xb, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_xa%0d", i), xa_q[xb+i], 100 + i);
      chk($sformatf("t1_xl%0d", i), xl_q[xb+i], (i == 2));
      chk($sformatf("t1_xw%0d", i), xw_q[xb+i], 1'b0);
    end
    finish_job("t1");

    // Two chained descriptors, write.
    xb = xa_q.size(); db = da_q.size();
    rw = 1'b1;
    start_cmd(8);
    wait_st("t2_end", 3'd6, 200);
    chk("t2_nd", da_q.size() - db, 4);
    chk("t2_d0", da_q[db], 8);
    chk("t2_d1", da_q[db+1], 9);
    chk("t2_d2", da_q[db+2], 12);
    chk("t2_d3", da_q[db+3], 13);
    chk("t2_nx", xa_q.size() - xb, 3);
    chk("t2_xa0", xa_q[xb], 200);
    chk("t2_xa1", xa_q[xb+1], 201);
    chk("t2_xa2", xa_q[xb+2], 300);
    chk("t2_xl0", xl_q[xb], 1'b0);
    chk("t2_xl1", xl_q[xb+1], 1'b1);
    chk("t2_xl2", xl_q[xb+2], 1'b1);
    chk("t2_xw0", xw_q[xb], 1'b1);
    chk("t2_xw2", xw_q[xb+2], 1'b1);
    finish_job("t2");

    // Burst split: len 10 with MAX_BURST 4 -> 4/4/2.
    xb = xa_q.size(); bb = bc_q.size();
    rw = 1'b0;
    start_cmd(16);
    wait_st("t3_end", 3'd6, 200);
    chk("t3_nx", xa_q.size() - xb, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_xa%0d", i), xa_q[xb+i], 400 + i);
    chk("t3_nb", bc_q.size() - bb, 3);
    chk("t3_b0", bc_q[bb], 4);
    chk("t3_b1", bc_q[bb+1], 4);
    chk("t3_b2", bc_q[bb+2], 2);
    chk("t3_g1", bg_q[bb+1], 1);
    chk("t3_g2", bg_q[bb+2], 1);
    finish_job("t3");

    // Two retries then ack: beat repeats at same address.
    xb = xa_q.size();
    rb = rty_seen;
    rty_base = rty_seen; rty_req = 2; rty_w = 500;
    start_cmd(20);
    wait_st("t4_end", 3'd6, 200);
    chk("t4_nrty", rty_seen - rb, 2);
    chk("t4_nx", xa_q.size() - xb, 2);
    chk("t4_xa0", xa_q[xb], 500);
    chk("t4_xa1", xa_q[xb+1], 501);
    chk("t4_sgst", sg_state, 8'h86);
    finish_job("t4");

    // Three retries: panic with buffer retry code.
    xb = xa_q.size();
    rb = rty_seen;
    rty_base = rty_seen; rty_req = 3; rty_w = 600;
    start_cmd(24);
    wait_st("t5_panic", 3'd7, 200);
    chk("t5_nrty", rty_seen - rb, 3);
    chk("t5_sgst", sg_state, 8'hC7);
    chk("t5_cyc", wb.wbs_cyc, 1'b0);
    chk("t5_nx", xa_q.size() - xb, 0);
    repeat (3) tick();
    chk("t5_hold", sg_state, 8'hC7);
    chk("t5_cdone", c_done, 1'b0);
    finish_job("t5");
    chk("t5_errkept", sg_state, 8'hC0);
    rty_req = 0; rty_w = -1;

    // Bus error on descriptor beat 0.
    err_w = 28; err_arm = 1'b1;
    start_cmd(28);
    wait_st("t6_panic", 3'd7, 200);
    chk("t6_sgst", sg_state, 8'h17);
    chk("t6_cyc", wb.wbs_cyc, 1'b0);
    err_arm = 1'b0;
    finish_job("t6");
    chk("t6_errkept", sg_state, 8'h10);

    // Zero-length descriptor skips straight to the next fetch.
    xb = xa_q.size(); db = da_q.size();
    start_cmd(32);
    chk("t7_errclr", sg_state[6:4], 3'd0);
    wait_st("t7_end", 3'd6, 200);
    chk("t7_nd", da_q.size() - db, 4);
    chk("t7_d1", da_q[db+1], 33);
    chk("t7_d2", da_q[db+2], 36);
    chk("t7_d3", da_q[db+3], 37);
    chk("t7_nx", xa_q.size() - xb, 1);
    chk("t7_xa0", xa_q[xb], 800);
    chk("t7_xl0", xl_q[xb], 1'b1);
    chk("t7_sgst", sg_state, 8'h86);
    finish_job("t7");

    // Reset in the middle of a burst.
    start_cmd(40);
    wait_st("t8_breq", 3'd2, 200);
    tick();
    chk("t8_inburst", ss_xfer, 1'b1);
    rst = 1'b1;
    #1;
    chk("t8_noxfer", ss_xfer, 1'b0);
    tick();
    chk_rst("t8");
    rst = 1'b0;
    tick();
    chk("t8_idle", sg_state, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
